multicycle_ctrl_ws: RTL and testbench

- Parametrised successor to the 4-state multicycle CPU controller.
- Widens the opcode to 4 bits, adding ALU-immediate, NOP and HALT instructions.
- Branch conditions now cover all four flags; memory accesses are stretched by a mem_ready wait-state handshake with a timeout watchdog.
- Sits between instruction register/flags and datapath control strobes of the 8-bit CPU.

---
 rtl/multicycle_ctrl_ws.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_ctrl_ws.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_ws.sv
// Multicycle controller for the 8-bit CPU with a mem_ready wait-state
// handshake, wait timeout watchdog and sticky error flags.
module multicycle_ctrl_ws #(
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 4,
    parameter int ALUOP_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         opcode,
    input  logic [2:0]         mode_flag,
    input  logic               zero,
    input  logic               carry,
    input  logic               negative,
    input  logic               overflow,
    input  logic               mem_ready,
    output logic               ir_memread,
    output logic               irwrite,
    output logic               pcwrite,
    output logic               pc_select,
    output logic               memread,
    output logic               memwrite,
    output logic               regwrite,
    output logic               memtoreg,
    output logic               alusrc,
    output logic [ALUOP_W-1:0] aluop,
    output logic               halted,
    output logic               bus_error,
    output logic               illegal_op,
    output logic [2:0]         state_out
);

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4
    } state_e;

    localparam logic [3:0] OP_LOAD   = 4'b0100;
    localparam logic [3:0] OP_STORE  = 4'b0101;
    localparam logic [3:0] OP_BRANCH = 4'b0110;
    localparam logic [3:0] OP_JUMP   = 4'b0111;
    localparam logic [3:0] OP_ADDI   = 4'b1000;
    localparam logic [3:0] OP_NOP    = 4'b1001;
    localparam logic [3:0] OP_HALT   = 4'b1111;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              bus_error_q, bus_error_d;
    logic              illegal_op_q, illegal_op_d;
    logic              branch_taken;
    logic              wait_expired;
    logic              is_load;

    assign is_load      = (opcode == OP_LOAD);
    assign wait_expired = !mem_ready && (wait_cnt_q == WAIT_LAST);

    always_comb begin
        branch_taken = 1'b0;
        unique case (mode_flag)
            3'b000: branch_taken = zero;
            3'b001: branch_taken = !zero;
            3'b010: branch_taken = negative;
            3'b011: branch_taken = !negative;
            3'b100: branch_taken = carry;
            3'b101: branch_taken = !carry;
            3'b110: branch_taken = overflow;
            3'b111: branch_taken = !overflow;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        ir_memread   = 1'b0;
        irwrite      = 1'b0;
        pcwrite      = 1'b0;
        pc_select    = 1'b0;
        memread      = 1'b0;
        memwrite     = 1'b0;
        regwrite     = 1'b0;
        memtoreg     = 1'b0;
        alusrc       = 1'b0;
        aluop        = '0;
        halted       = 1'b0;
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        bus_error_d  = bus_error_q;
        illegal_op_d = illegal_op_q;

        unique case (state_q)
            FETCH: begin
                ir_memread = 1'b1;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = EXEC;
                end else if (wait_expired) begin
                    bus_error_d = 1'b1;
                    state_d     = HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            EXEC: begin
                case (opcode)
                    4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
                        aluop[1:0] = opcode[1:0];
                        state_d    = WB;
                    end
                    OP_ADDI: begin
                        alusrc  = 1'b1;
                        state_d = WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alusrc  = 1'b1;
                        state_d = MEM;
                    end
                    OP_BRANCH: begin
                        pcwrite   = branch_taken;
                        pc_select = branch_taken;
                        state_d   = FETCH;
                    end
                    OP_JUMP: begin
                        pcwrite   = 1'b1;
                        pc_select = 1'b1;
                        state_d   = FETCH;
                    end
                    OP_NOP:  state_d = FETCH;
                    OP_HALT: state_d = HALT;
                    default: begin
                        illegal_op_d = 1'b1;
                        state_d      = HALT;
                    end
                endcase
            end
            MEM: begin
                alusrc   = 1'b1;
                memread  = is_load;
                memwrite = (opcode == OP_STORE);
                if (mem_ready) begin
                    state_d = is_load ? WB : FETCH;
                end else if (wait_expired) begin
                    bus_error_d = 1'b1;
                    state_d     = HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            WB: begin
                regwrite = 1'b1;
                memtoreg = is_load;
                state_d  = FETCH;
            end
            HALT: halted = 1'b1;
            default: state_d = FETCH;
        endcase

        // Every access phase starts its watchdog from zero.
        if (state_d != state_q && (state_d == FETCH || state_d == MEM)) begin
            wait_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            wait_cnt_q   <= '0;
            bus_error_q  <= 1'b0;
            illegal_op_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            bus_error_q  <= bus_error_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    assign bus_error  = bus_error_q;
    assign illegal_op = illegal_op_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_ws.sv
// Directed bench for multicycle_ctrl_ws: an instruction-level model expands
// each instruction into per-cycle expected outputs, checked every cycle.
module tb_multicycle_ctrl_ws;

    localparam int MAX_WAIT = 8;

    localparam int B_IRM = 16;
    localparam int B_IRW = 15;
    localparam int B_PCW = 14;
    localparam int B_PCS = 13;
    localparam int B_MRD = 12;
    localparam int B_MWR = 11;
    localparam int B_RGW = 10;
    localparam int B_MTR = 9;
    localparam int B_ALS = 8;
    localparam int B_HLT = 5;
    localparam int B_BE  = 4;
    localparam int B_IL  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic [2:0] mode_flag;
    logic       zero, carry, negative, overflow;
    logic       mem_ready;
    logic       ir_memread, irwrite, pcwrite, pc_select;
    logic       memread, memwrite, regwrite, memtoreg, alusrc;
    logic [1:0] aluop;
    logic       halted, bus_error, illegal_op;
    logic [2:0] state_out;

    multicycle_ctrl_ws #(.MAX_WAIT(MAX_WAIT), .WAIT_W(4), .ALUOP_W(2)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mode_flag(mode_flag),
        .zero(zero), .carry(carry), .negative(negative),
        .overflow(overflow), .mem_ready(mem_ready),
        .ir_memread(ir_memread), .irwrite(irwrite), .pcwrite(pcwrite),
        .pc_select(pc_select), .memread(memread), .memwrite(memwrite),
        .regwrite(regwrite), .memtoreg(memtoreg), .alusrc(alusrc),
        .aluop(aluop), .halted(halted), .bus_error(bus_error),
        .illegal_op(illegal_op), .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [3:0]  op;
        logic [2:0]  mode;
        logic [3:0]  flg;
        logic        rdy;
        logic        chk;
        logic [16:0] exp;
    } vec_t;

    vec_t q[$];
    logic m_be = 1'b0;
    logic m_il = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [16:0] e0(input logic [2:0] st);
        logic [16:0] e;
        e        = '0;
        e[2:0]   = st;
        e[B_HLT] = (st == 3'd4);
        e[B_BE]  = m_be;
        e[B_IL]  = m_il;
        return e;
    endfunction

    task automatic push(input logic r, input logic [3:0] op,
                        input logic [2:0] md, input logic [3:0] fl,
                        input logic rd, input logic ck,
                        input logic [16:0] e);
        vec_t v;
        v.rst = r; v.op = op; v.mode = md; v.flg = fl;
        v.rdy = rd; v.chk = ck; v.exp = e;
        q.push_back(v);
    endtask

    task automatic do_reset();
        push(1'b1, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0, '0);
        m_be = 1'b0;
        m_il = 1'b0;
    endtask

    // HALT ignores opcode and mem_ready; drive them active to prove it.
    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++)
            push(1'b0, 4'b0010, 3'd0, 4'd0, 1'b1, 1'b1, e0(3'd4));
    endtask

    // flg = {zero, carry, negative, overflow}
    task automatic run(input logic [3:0] op, input logic [2:0] md,
                       input logic [3:0] fl, input int fw, input int mw,
                       input bit abort);
        logic [16:0] e;
        logic [7:0]  conds;
        bit          is_ld, is_st, to_wb, to_mem, to_halt;
        is_ld = (op == 4'b0100);
        is_st = (op == 4'b0101);
        for (int i = 0; i < (fw < MAX_WAIT ? fw : MAX_WAIT); i++) begin
            e = e0(3'd0); e[B_IRM] = 1'b1;
            push(1'b0, op, md, fl, 1'b0, 1'b1, e);
        end
        if (fw >= MAX_WAIT) begin
            m_be = 1'b1;
            halt_cycles(3);
            return;
        end
        e = e0(3'd0);
        e[B_IRM] = 1'b1; e[B_IRW] = 1'b1; e[B_PCW] = 1'b1;
        push(1'b0, op, md, fl, 1'b1, 1'b1, e);

        e = e0(3'd1);
        to_wb = 0; to_mem = 0; to_halt = 0;
        conds = {~fl[0], fl[0], ~fl[2], fl[2], ~fl[1], fl[1], ~fl[3], fl[3]};
        if (op < 4'd4) begin
            e[7:6] = op[1:0]; to_wb = 1;
        end else if (op == 4'b1000) begin
            e[B_ALS] = 1'b1; to_wb = 1;
        end else if (is_ld || is_st) begin
            e[B_ALS] = 1'b1; to_mem = 1;
        end else if (op == 4'b0110) begin
            e[B_PCW] = conds[md]; e[B_PCS] = conds[md];
        end else if (op == 4'b0111) begin
            e[B_PCW] = 1'b1; e[B_PCS] = 1'b1;
        end else if (op == 4'b1001) begin
            to_halt = 0;
        end else begin
            to_halt = 1;
        end
        push(1'b0, op, md, fl, 1'b0, 1'b1, e);
        if (to_halt) begin
            if (op != 4'b1111) m_il = 1'b1;
            halt_cycles(3);
            return;
        end

        if (to_mem) begin
            for (int i = 0; i < (mw < MAX_WAIT ? mw : MAX_WAIT); i++) begin
                e = e0(3'd2); e[B_ALS] = 1'b1;
                e[B_MRD] = is_ld; e[B_MWR] = is_st;
                push(1'b0, op, md, fl, 1'b0, 1'b1, e);
            end
            if (mw >= MAX_WAIT) begin
                m_be = 1'b1;
                halt_cycles(3);
                return;
            end
            e = e0(3'd2); e[B_ALS] = 1'b1;
            e[B_MRD] = is_ld; e[B_MWR] = is_st;
            if (abort) begin
                push(1'b1, op, md, fl, 1'b0, 1'b1, e);
                m_be = 1'b0;
                m_il = 1'b0;
                return;
            end
            push(1'b0, op, md, fl, 1'b1, 1'b1, e);
            if (is_ld) to_wb = 1;
        end

        if (to_wb) begin
            e = e0(3'd3); e[B_RGW] = 1'b1; e[B_MTR] = is_ld;
            push(1'b0, op, md, fl, 1'b0, 1'b1, e);
        end
    endtask

    task automatic chk_len(input string nm, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_bad++;
            $display("FAIL len_%s: got %0d cycles, required %0d", nm, got, req);
        end
    endtask

    task automatic run_len(input string nm, input logic [3:0] op,
                           input logic [2:0] md, input logic [3:0] fl,
                           input int fw, input int mw, input int req);
        int n0;
        n0 = q.size();
        run(op, md, fl, fw, mw, 0);
        chk_len(nm, q.size() - n0, req);
    endtask

    initial begin
        vec_t        v;
        logic [16:0] act;
        int          cyc;

        do_reset();
        run_len("alu_0010", 4'b0010, 3'd0, 4'd0, 0, 0, 3);
        run_len("alu_0011", 4'b0011, 3'd0, 4'd0, 0, 0, 3);
        run_len("addi", 4'b1000, 3'd0, 4'd0, 0, 0, 3);
        run_len("load_w3", 4'b0100, 3'd0, 4'd0, 0, 3, 7);
        run_len("load_w0", 4'b0100, 3'd0, 4'd0, 0, 0, 4);
        run_len("store_w0", 4'b0101, 3'd0, 4'd0, 0, 0, 3);
        run_len("br_c1", 4'b0110, 3'b100, 4'b0100, 0, 0, 2);
        run_len("br_c0", 4'b0110, 3'b100, 4'b1011, 0, 0, 2);
        run_len("br_nz", 4'b0110, 3'b001, 4'b0000, 0, 0, 2);
        run_len("br_nv", 4'b0110, 3'b111, 4'b0001, 0, 0, 2);
        run_len("br_neg", 4'b0110, 3'b010, 4'b0010, 0, 0, 2);
        run_len("jump", 4'b0111, 3'd0, 4'd0, 0, 0, 2);
        run_len("nop", 4'b1001, 3'd0, 4'd0, 0, 0, 2);
        run_len("fetch_w7", 4'b0001, 3'd0, 4'd0, 7, 0, 10);
        run_len("load_f5m7", 4'b0100, 3'd0, 4'd0, 5, 7, 16);
        run(4'b0101, 3'd0, 4'd0, 2, 2, 1);
        run(4'b0000, 3'd0, 4'd0, 0, 0, 0);
        run(4'b1010, 3'd0, 4'd0, 0, 0, 0);
        do_reset();
        run(4'b1111, 3'd0, 4'd0, 1, 0, 0);
        do_reset();
        run(4'b0010, 3'd0, 4'd0, 8, 0, 0);
        do_reset();
        run(4'b0010, 3'd0, 4'd0, 0, 0, 0);
        run(4'b0100, 3'd0, 4'd0, 0, 8, 0);
        do_reset();
        run(4'b1001, 3'd0, 4'd0, 0, 0, 0);

        cyc = 0;
        while (q.size() > 0) begin
            v = q.pop_front();
            rst = v.rst;
            opcode = v.op;
            mode_flag = v.mode;
            {zero, carry, negative, overflow} = v.flg;
            mem_ready = v.rdy;
            @(negedge clk);
            if (v.chk) begin
                act = {ir_memread, irwrite, pcwrite, pc_select, memread,
                       memwrite, regwrite, memtoreg, alusrc, aluop,
                       halted, bus_error, illegal_op, state_out};
                n_cmp++;
                if (act !== v.exp) begin
                    n_bad++;
                    $display("FAIL outs cyc %0d: got %05h required %05h",
                             cyc, act, v.exp);
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
